complete_buffer: RTL and testbench
==================================

COMPLETE_BUFFER -- requirements
Module: complete_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count of the completion FIFO; power of two, at least 4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn, input, 1, reset; synchronous, active-high (1 = reset), sampled on the rising edge of clk.
REQ-004 SHALL have ports aluK_valid, input, 1, ALU K (K=0..2) result valid this cycle.
REQ-005 SHALL have ports aluK_pc, input, 32, PC of the ALU K result.
REQ-006 SHALL have ports aluK_data, input, 32, destination value from ALU K.
REQ-007 SHALL have ports aluK_dr, input, 6, physical destination register for ALU K.
REQ-008 SHALL have ports lsu_valid / lsu_pc / lsu_data / lsu_dr, inputs, 1/32/32/6, load-store completion with the same meaning as the ALU ports.
REQ-009 SHALL have port lsu_is_store, input, 1, LSU completion is a store (no register result).
REQ-010 SHALL have port rob_ready, input, 1, ROB accepts the presented completions this cycle.
REQ-011 SHALL have ports complete_valid_J, output, 1, completion slot J (J=0..1) holds a real entry.
REQ-012 SHALL have ports complete_pc_J / new_dr_data_J / complete_dr_J / is_store_J, outputs, 32/32/6/1, contents of slot J.
REQ-013 SHALL have port accept_ok, output, 1, at least 4 free entries; issue may proceed.
REQ-014 SHALL have port count, output, log2(DEPTH)+1, occupied entries.
REQ-015 SHALL have port overflow, output, 1, sticky error flag.

Function
REQ-016 SHALL write the valid inputs each cycle into consecutive tail entries in fixed order ALU0, ALU1, ALU2, LSU; invalid inputs consume no entry.
REQ-017 SHALL drive slot 0 from the head entry and slot 1 from head+1 combinationally from registered state (show-ahead).
REQ-018 SHALL pop min(2, count) entries on a rising edge where rob_ready=1; no pop when rob_ready=0.
REQ-019 SHALL drive, for an unused slot (J >= count): valid=0, pc=32'd1, data=32'd1, dr=0, is_store=0.
REQ-020 SHALL give a minimum latency of one cycle: an entry pushed at edge N appears on the outputs after edge N; no input-to-output bypass.
REQ-021 SHALL compute a simultaneous push and pop as count_next = count + pushes - pops, with pops based on the pre-edge count; an entry pushed into an empty buffer is not popped at the same edge.
REQ-022 SHALL keep head and tail pointers modulo DEPTH and wrap without a bubble.
REQ-023 SHALL store data=0 and dr=0 with is_store=1 when lsu_is_store=1.
REQ-024 SHALL drive accept_ok = (DEPTH - count) >= 4, decoded from registered count only.
REQ-025 SHALL, when pushes exceed the free entries after this edge's pop, write only the earliest in push order until full, drop the rest, and set overflow.
REQ-026 SHALL hold overflow at 1 until reset.

Reset
REQ-027 SHALL, while rstn=1 at a rising edge, clear head, tail, count and overflow, ignoring simultaneous pushes and pops.
REQ-028 SHALL, after reset, drive all outputs to the unused-slot values of REQ-019, with count=0, accept_ok=1 and overflow=0.
REQ-029 SHALL discard in-flight contents on a mid-operation reset; contents are not required to be cleared.

Verification
REQ-030 Reset then idle -> complete_valid_0/1=0, complete_pc_0/1=32'd1, count=0, accept_ok=1.
REQ-031 alu1 (pc=0x10, data=5, dr=7) and lsu (pc=0x14, data=9, dr=8) valid in one cycle, rob_ready=0 -> next cycle slot0={0x10,5,7}, slot1={0x14,9,8}, count=2.
REQ-032 From REQ-031 raise rob_ready for one edge while alu0 pushes pc=0x18 -> next cycle count=1, slot0 pc=0x18, slot1 valid=0.
REQ-033 4 pushes/cycle for 2 cycles with rob_ready=0, DEPTH=8 -> count=8, accept_ok=0; a third 4-push cycle -> overflow=1, count stays 8.
REQ-034 Alternate 3 pushes and 2 pops for 20 cycles -> PC sequence on the outputs matches push order across pointer wrap; no loss or duplication.
REQ-035 Store completion from lsu (pc=0x20, data=0xDEAD, dr=3, is_store=1) -> slot0 is_store=1, data=0, dr=0; rstn=1 with count=5 -> next cycle count=0, overflow=0.

Source files
------------

// File: rtl/complete_buffer.sv
`default_nettype none
// ============================================================================
// Module   : complete_buffer
// Purpose  : Completion FIFO between the execution units (three ALUs and one
//            LSU) and the ROB. Each cycle the valid results are appended in
//            the fixed order ALU0, ALU1, ALU2, LSU. The two oldest entries
//            are presented show-ahead on two completion slots, and up to two
//            entries retire per cycle when the ROB is ready.
// Ports    : clk, rstn           - clock; synchronous active-high reset
//            aluK_* (K=0..2)     - ALU result valid/pc/data/dest register
//            lsu_*               - LSU result valid/pc/data/dest register/store
//            rob_ready           - ROB takes the presented slots this edge
//            complete_*_J (J=0,1)- completion slot contents
//            accept_ok           - at least four free entries
//            count               - occupied entries
//            overflow            - sticky flag: a completion was dropped
// Revision : 1.0 - initial release
// ============================================================================
module complete_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     alu0_valid,
  input  logic [31:0]              alu0_pc,
  input  logic [31:0]              alu0_data,
  input  logic [5:0]               alu0_dr,
  input  logic                     alu1_valid,
  input  logic [31:0]              alu1_pc,
  input  logic [31:0]              alu1_data,
  input  logic [5:0]               alu1_dr,
  input  logic                     alu2_valid,
  input  logic [31:0]              alu2_pc,
  input  logic [31:0]              alu2_data,
  input  logic [5:0]               alu2_dr,
  input  logic                     lsu_valid,
  input  logic [31:0]              lsu_pc,
  input  logic [31:0]              lsu_data,
  input  logic [5:0]               lsu_dr,
  input  logic                     lsu_is_store,
  input  logic                     rob_ready,
  output logic                     complete_valid_0,
  output logic [31:0]              complete_pc_0,
  output logic [31:0]              new_dr_data_0,
  output logic [5:0]               complete_dr_0,
  output logic                     is_store_0,
  output logic                     complete_valid_1,
  output logic [31:0]              complete_pc_1,
  output logic [31:0]              new_dr_data_1,
  output logic [5:0]               complete_dr_1,
  output logic                     is_store_1,
  output logic                     accept_ok,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  // Internal count arithmetic carries one spare bit so count + pushes never
  // wraps before the free-space comparison.
  localparam int CW = AW + 2;

  // Entry storage; contents are never reset, only the pointers are.
  logic [31:0]   r_pc   [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [5:0]    r_dr   [DEPTH];
  logic          r_st   [DEPTH];

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  // Per-source views in push order.
  logic [3:0]    w_src_vld;
  logic [31:0]   w_src_pc   [4];
  logic [31:0]   w_src_data [4];
  logic [5:0]    w_src_dr   [4];
  logic [3:0]    w_src_st;

  logic [CW-1:0] w_pops;
  logic [CW-1:0] w_free;
  logic [CW-1:0] w_nacc;
  logic [AW-1:0] w_wptr;
  logic [AW-1:0] w_wr_idx [4];
  logic [3:0]    w_wr_en;
  logic          w_drop;
  logic [AW-1:0] w_idx1;

  always_comb begin
    w_src_vld     = {lsu_valid, alu2_valid, alu1_valid, alu0_valid};
    w_src_pc[0]   = alu0_pc;
    w_src_pc[1]   = alu1_pc;
    w_src_pc[2]   = alu2_pc;
    w_src_pc[3]   = lsu_pc;
    w_src_data[0] = alu0_data;
    w_src_data[1] = alu1_data;
    w_src_data[2] = alu2_data;
    // A store has no register result; its data and destination read as zero.
    w_src_data[3] = lsu_is_store ? 32'd0 : lsu_data;
    w_src_dr[0]   = alu0_dr;
    w_src_dr[1]   = alu1_dr;
    w_src_dr[2]   = alu2_dr;
    w_src_dr[3]   = lsu_is_store ? 6'd0 : lsu_dr;
    w_src_st      = {lsu_is_store, 3'b000};
  end

  // Pops are decided from the pre-edge count, so an entry written this edge
  // can never be retired on the same edge.
  always_comb begin
    w_pops = '0;
    if (rob_ready) begin
      w_pops = (r_count >= CW'(2)) ? CW'(2) : r_count;
    end
    w_free = CW'(DEPTH) - r_count + w_pops;
  end

  // Walk the sources in priority order, giving each valid one the next tail
  // slot while space remains; anything beyond that is dropped.
  always_comb begin
    w_wr_en = '0;
    w_drop  = 1'b0;
    w_nacc  = '0;
    w_wptr  = r_tail;
    for (int i = 0; i < 4; i++) begin
      w_wr_idx[i] = w_wptr;
      if (w_src_vld[i]) begin
        if (w_nacc < w_free) begin
          w_wr_en[i] = 1'b1;
          w_nacc     = w_nacc + CW'(1);
          w_wptr     = w_wptr + AW'(1);
        end else begin
          w_drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_head     <= r_head + w_pops[AW-1:0];
      r_tail     <= w_wptr;
      r_count    <= r_count + w_nacc - w_pops;
      r_overflow <= r_overflow | w_drop;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wr_en[i]) begin
          r_pc[w_wr_idx[i]]   <= w_src_pc[i];
          r_data[w_wr_idx[i]] <= w_src_data[i];
          r_dr[w_wr_idx[i]]   <= w_src_dr[i];
          r_st[w_wr_idx[i]]   <= w_src_st[i];
        end
      end
    end
  end

  // Show-ahead slots; unused slots present the fixed idle pattern.
  assign w_idx1 = r_head + AW'(1);

  always_comb begin
    complete_valid_0 = 1'b0;
    complete_pc_0    = 32'd1;
    new_dr_data_0    = 32'd1;
    complete_dr_0    = 6'd0;
    is_store_0       = 1'b0;
    if (r_count != '0) begin
      complete_valid_0 = 1'b1;
      complete_pc_0    = r_pc[r_head];
      new_dr_data_0    = r_data[r_head];
      complete_dr_0    = r_dr[r_head];
      is_store_0       = r_st[r_head];
    end
  end

  always_comb begin
    complete_valid_1 = 1'b0;
    complete_pc_1    = 32'd1;
    new_dr_data_1    = 32'd1;
    complete_dr_1    = 6'd0;
    is_store_1       = 1'b0;
    if (r_count > CW'(1)) begin
      complete_valid_1 = 1'b1;
      complete_pc_1    = r_pc[w_idx1];
      new_dr_data_1    = r_data[w_idx1];
      complete_dr_1    = r_dr[w_idx1];
      is_store_1       = r_st[w_idx1];
    end
  end

  assign accept_ok = (CW'(DEPTH) - r_count) >= CW'(4);
  assign count     = r_count[AW:0];
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_complete_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_complete_buffer
// Purpose  : Self-checking bench for complete_buffer (DEPTH=8). Every edge is
//            checked against a queue-based model; directed sequences and a
//            vector table add hand-derived expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_complete_buffer;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic [5:0]  dr;
    logic        st;
  } ent_t;

  typedef struct packed {
    logic        rst;
    logic        rr;
    logic [3:0]  v;
    logic [31:0] base;
    logic [3:0]  e_cnt;
    logic        e_v0;
    logic [31:0] e_pc0;
    logic        e_v1;
    logic [31:0] e_pc1;
    logic        e_acc;
    logic        e_ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        rob_ready = 1'b0;
  logic        lsu_is_store = 1'b0;
  logic        s_valid [4];
  logic [31:0] s_pc    [4];
  logic [31:0] s_data  [4];
  logic [5:0]  s_dr    [4];

  logic        cv0, cv1, st0, st1, accept_ok, overflow;
  logic [31:0] cpc0, cpc1, cd0, cd1;
  logic [5:0]  cdr0, cdr1;
  logic [3:0]  count;

  int checks = 0;
  int failures = 0;

  ent_t mq[$];
  bit   m_ovf = 1'b0;
  int   pc_seq = 32'h1000;

  always #5 clk = ~clk;

  complete_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .alu0_valid(s_valid[0]), .alu0_pc(s_pc[0]), .alu0_data(s_data[0]), .alu0_dr(s_dr[0]),
    .alu1_valid(s_valid[1]), .alu1_pc(s_pc[1]), .alu1_data(s_data[1]), .alu1_dr(s_dr[1]),
    .alu2_valid(s_valid[2]), .alu2_pc(s_pc[2]), .alu2_data(s_data[2]), .alu2_dr(s_dr[2]),
    .lsu_valid(s_valid[3]), .lsu_pc(s_pc[3]), .lsu_data(s_data[3]), .lsu_dr(s_dr[3]),
    .lsu_is_store(lsu_is_store), .rob_ready(rob_ready),
    .complete_valid_0(cv0), .complete_pc_0(cpc0), .new_dr_data_0(cd0),
    .complete_dr_0(cdr0), .is_store_0(st0),
    .complete_valid_1(cv1), .complete_pc_1(cpc1), .new_dr_data_1(cd1),
    .complete_dr_1(cdr1), .is_store_1(st1),
    .accept_ok(accept_ok), .count(count), .overflow(overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_src();
    for (int k = 0; k < 4; k++) begin
      s_valid[k] = 1'b0;
      s_pc[k]    = 32'd0;
      s_data[k]  = 32'd0;
      s_dr[k]    = 6'd0;
    end
    lsu_is_store = 1'b0;
  endtask

  task automatic set_src(input int k, input logic [31:0] pc, input logic [31:0] d,
                         input logic [5:0] dr);
    s_valid[k] = 1'b1;
    s_pc[k]    = pc;
    s_data[k]  = d;
    s_dr[k]    = dr;
  endtask

  // Reference behaviour: retire up to two of the existing entries, then
  // append valid sources in order while room remains, flagging any drop.
  task automatic model_edge();
    int npop;
    ent_t e;
    if (rstn) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      npop = rob_ready ? ((mq.size() >= 2) ? 2 : mq.size()) : 0;
      for (int i = 0; i < npop; i++) void'(mq.pop_front());
      for (int k = 0; k < 4; k++) begin
        if (s_valid[k]) begin
          if (mq.size() < DEPTH) begin
            e.pc = s_pc[k];
            e.st = (k == 3) && lsu_is_store;
            e.data = e.st ? 32'd0 : s_data[k];
            e.dr = e.st ? 6'd0 : s_dr[k];
            mq.push_back(e);
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_model();
    ent_t idle;
    ent_t e0, e1;
    idle = '{pc: 32'd1, data: 32'd1, dr: 6'd0, st: 1'b0};
    e0 = (mq.size() > 0) ? mq[0] : idle;
    e1 = (mq.size() > 1) ? mq[1] : idle;
    chk("m_valid0", {31'd0, cv0}, {31'd0, mq.size() > 0});
    chk("m_pc0", cpc0, e0.pc);
    chk("m_data0", cd0, e0.data);
    chk("m_dr0", {26'd0, cdr0}, {26'd0, e0.dr});
    chk("m_st0", {31'd0, st0}, {31'd0, e0.st});
    chk("m_valid1", {31'd0, cv1}, {31'd0, mq.size() > 1});
    chk("m_pc1", cpc1, e1.pc);
    chk("m_data1", cd1, e1.data);
    chk("m_dr1", {26'd0, cdr1}, {26'd0, e1.dr});
    chk("m_st1", {31'd0, st1}, {31'd0, e1.st});
    chk("m_count", {28'd0, count}, mq.size());
    chk("m_accept", {31'd0, accept_ok}, {31'd0, (DEPTH - mq.size()) >= 4});
    chk("m_ovf", {31'd0, overflow}, {31'd0, m_ovf});
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  vec_t vt [13];

  initial begin
    clear_src();
    rstn = 1'b1;
    rob_ready = 1'b0;
    step();
    step();
    rstn = 1'b0;
    clear_src();
    step();
    chk("idle_v0", {31'd0, cv0}, 32'd0);
    chk("idle_v1", {31'd0, cv1}, 32'd0);
    chk("idle_pc0", cpc0, 32'd1);
    chk("idle_pc1", cpc1, 32'd1);
    chk("idle_cnt", {28'd0, count}, 32'd0);
    chk("idle_acc", {31'd0, accept_ok}, 32'd1);

    // Two results in one cycle, ROB stalled.
    set_src(1, 32'h10, 32'd5, 6'd7);
    set_src(3, 32'h14, 32'd9, 6'd8);
    step();
    chk("d31_pc0", cpc0, 32'h10);
    chk("d31_data0", cd0, 32'd5);
    chk("d31_dr0", {26'd0, cdr0}, 32'd7);
    chk("d31_pc1", cpc1, 32'h14);
    chk("d31_data1", cd1, 32'd9);
    chk("d31_dr1", {26'd0, cdr1}, 32'd8);
    chk("d31_cnt", {28'd0, count}, 32'd2);

    // Retire both while a new result arrives.
    clear_src();
    set_src(0, 32'h18, 32'd11, 6'd2);
    rob_ready = 1'b1;
    step();
    chk("d32_cnt", {28'd0, count}, 32'd1);
    chk("d32_pc0", cpc0, 32'h18);
    chk("d32_v1", {31'd0, cv1}, 32'd0);

    // Store completion: data and destination read back as zero.
    clear_src();
    set_src(3, 32'h20, 32'hDEAD, 6'd3);
    lsu_is_store = 1'b1;
    step();
    chk("d35_pc0", cpc0, 32'h20);
    chk("d35_st0", {31'd0, st0}, 32'd1);
    chk("d35_data0", cd0, 32'd0);
    chk("d35_dr0", {26'd0, cdr0}, 32'd0);
    clear_src();
    rob_ready = 1'b0;
    for (int k = 0; k < 4; k++) set_src(k, 32'h30 + 4 * k, k, 6'(k));
    step();
    chk("d35_cnt5", {28'd0, count}, 32'd5);
    rstn = 1'b1;
    step();
    rstn = 1'b0;
    clear_src();
    chk("d35_rst_cnt", {28'd0, count}, 32'd0);
    chk("d35_rst_ovf", {31'd0, overflow}, 32'd0);

    // Vector table: source k carries pc = base + 4*k.
    vt[0]  = '{1, 0, 4'hF, 32'h100, 0, 0, 32'd1,   0, 32'd1,   1, 0};
    vt[1]  = '{0, 0, 4'hF, 32'h100, 4, 1, 32'h100, 1, 32'h104, 1, 0};
    vt[2]  = '{0, 0, 4'hF, 32'h200, 8, 1, 32'h100, 1, 32'h104, 0, 0};
    vt[3]  = '{0, 0, 4'hF, 32'h300, 8, 1, 32'h100, 1, 32'h104, 0, 1};
    vt[4]  = '{0, 1, 4'h0, 32'h0,   6, 1, 32'h108, 1, 32'h10C, 0, 1};
    vt[5]  = '{0, 1, 4'hF, 32'h400, 8, 1, 32'h200, 1, 32'h204, 0, 1};
    vt[6]  = '{0, 1, 4'h0, 32'h0,   6, 1, 32'h208, 1, 32'h20C, 0, 1};
    vt[7]  = '{0, 1, 4'h0, 32'h0,   4, 1, 32'h400, 1, 32'h404, 1, 1};
    vt[8]  = '{0, 1, 4'h0, 32'h0,   2, 1, 32'h408, 1, 32'h40C, 1, 1};
    vt[9]  = '{0, 1, 4'h0, 32'h0,   0, 0, 32'd1,   0, 32'd1,   1, 1};
    vt[10] = '{1, 1, 4'hF, 32'h700, 0, 0, 32'd1,   0, 32'd1,   1, 0};
    vt[11] = '{0, 1, 4'h1, 32'h500, 1, 1, 32'h500, 0, 32'd1,   1, 0};
    vt[12] = '{0, 1, 4'hA, 32'h600, 2, 1, 32'h604, 1, 32'h60C, 1, 0};
    for (int i = 0; i < 13; i++) begin
      clear_src();
      for (int k = 0; k < 4; k++)
        if (vt[i].v[k]) set_src(k, vt[i].base + 32'(4 * k), vt[i].base + 32'(k), 6'(k + 1));
      rstn = vt[i].rst;
      rob_ready = vt[i].rr;
      step();
      chk($sformatf("vt%0d_cnt", i), {28'd0, count}, {28'd0, vt[i].e_cnt});
      chk($sformatf("vt%0d_v0", i), {31'd0, cv0}, {31'd0, vt[i].e_v0});
      chk($sformatf("vt%0d_pc0", i), cpc0, vt[i].e_pc0);
      chk($sformatf("vt%0d_v1", i), {31'd0, cv1}, {31'd0, vt[i].e_v1});
      chk($sformatf("vt%0d_pc1", i), cpc1, vt[i].e_pc1);
      chk($sformatf("vt%0d_acc", i), {31'd0, accept_ok}, {31'd0, vt[i].e_acc});
      chk($sformatf("vt%0d_ovf", i), {31'd0, overflow}, {31'd0, vt[i].e_ovf});
    end

    // Alternating three pushes / two pops across pointer wrap.
    rstn = 1'b1;
    clear_src();
    step();
    rstn = 1'b0;
    for (int c = 0; c < 20; c++) begin
      clear_src();
      if (c % 2 == 0) begin
        rob_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          set_src(k, pc_seq, $urandom, 6'($urandom));
          pc_seq += 4;
        end
      end else begin
        rob_ready = 1'b1;
      end
      step();
    end

    // Random traffic with occasional reset.
    for (int c = 0; c < 400; c++) begin
      clear_src();
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 99) < 45) begin
          set_src(k, pc_seq, $urandom, 6'($urandom));
          pc_seq += 4;
        end
      end
      lsu_is_store = $urandom_range(0, 2) == 0;
      rob_ready = $urandom_range(0, 99) < 55;
      rstn = $urandom_range(0, 59) == 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
